window_buffer_kxk: RTL and testbench

WINDOW_BUFFER_KXK -- requirements
Module: window_buffer_kxk

---
 rtl/window_buffer_kxk.sv | 97 +++++++++
 tb/tb_window_buffer_kxk.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/window_buffer_kxk.sv
// KxK sliding-window register array fed one vertical column of K pixels per beat.
// Tracks column/output-row position and flags full, row-final and frame-final windows.
module window_buffer_kxk #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K          = 5,
  parameter int unsigned COLS       = 640,
  parameter int unsigned ROWS       = 480,
  localparam int unsigned CW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned RW        = (ROWS - K + 1 > 1) ? $clog2(ROWS - K + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      valid_i,
  input  logic [K*DATA_WIDTH-1:0]   taps_i,
  output logic [K*K*DATA_WIDTH-1:0] window_o,
  output logic                      valid_o,
  output logic                      row_end_o,
  output logic                      frame_end_o,
  output logic [CW-1:0]             col_o,
  output logic [RW-1:0]             row_o
);

  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - K);

  // Element [r][c] sits at flat index r*K+c, matching the window_o layout.
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept;
  logic          col_wrap;
  logic          row_wrap;
  logic          full_win;

  assign accept   = valid_i & ~clear_i;
  assign col_wrap = (col_q == COL_LAST);
  assign row_wrap = (row_q == ROW_LAST);
  assign full_win = (col_q >= COL_FIRST);

  always_comb begin
    win_d = win_q;
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K) - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = taps_i[r*DATA_WIDTH +: DATA_WIDTH];
      end
      if (col_wrap) begin
        col_d = '0;
        row_d = row_wrap ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      valid_o     <= 1'b0;
      row_end_o   <= 1'b0;
      frame_end_o <= 1'b0;
      col_o       <= '0;
      row_o       <= '0;
    end else if (clear_i) begin
      win_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      valid_o     <= 1'b0;
      row_end_o   <= 1'b0;
      frame_end_o <= 1'b0;
      col_o       <= '0;
      row_o       <= '0;
    end else begin
      win_q       <= win_d;
      col_q       <= col_d;
      row_q       <= row_d;
      valid_o     <= accept & full_win;
      row_end_o   <= accept & full_win & col_wrap;
      frame_end_o <= accept & full_win & col_wrap & row_wrap;
      if (accept) begin
        col_o <= col_q;
        row_o <= row_q;
      end
    end
  end

  assign window_o = win_q;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// Directed, table-driven bench for window_buffer_kxk with K=3, COLS=6, ROWS=5.
module tb_window_buffer_kxk;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int COLS = 6;
  localparam int ROWS = 5;
  localparam int NB   = COLS * (ROWS - K + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear_i = 1'b0;
  logic              valid_i = 1'b0;
  logic [K*DW-1:0]   taps_i = '0;
  logic [K*K*DW-1:0] window_o;
  logic              valid_o;
  logic              row_end_o;
  logic              frame_end_o;
  logic [2:0]        col_o;
  logic [1:0]        row_o;

  window_buffer_kxk #(
    .DATA_WIDTH(DW),
    .K(K),
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear_i(clear_i),
    .valid_i(valid_i),
    .taps_i(taps_i),
    .window_o(window_o),
    .valid_o(valid_o),
    .row_end_o(row_end_o),
    .frame_end_o(frame_end_o),
    .col_o(col_o),
    .row_o(row_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  typedef struct {
    logic [K*DW-1:0]   taps;
    bit                ev;
    bit                ere;
    bit                efe;
    int                ecol;
    int                erow;
    logic [K*K*DW-1:0] ewin;
  } vec_t;

  vec_t tbl[NB];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pixel value for image row r of the window, column col, output row orow.
  function automatic logic [7:0] pix(input int r, input int col, input int orow);
    return 8'(10 * r + col + 30 * orow);
  endfunction

  task automatic beat(input vec_t v, input string tag);
    valid_i = 1'b1;
    taps_i  = v.taps;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk({tag, " valid_o"}, 128'(valid_o), 128'(v.ev));
    chk({tag, " row_end_o"}, 128'(row_end_o), 128'(v.ere));
    chk({tag, " frame_end_o"}, 128'(frame_end_o), 128'(v.efe));
    chk({tag, " col_o"}, 128'(col_o), 128'(v.ecol));
    chk({tag, " row_o"}, 128'(row_o), 128'(v.erow));
    if (v.ev) chk({tag, " window_o"}, 128'(window_o), 128'(v.ewin));
    if (valid_o) pulses++;
  endtask

  task automatic idle(input int n, input string tag);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk({tag, " idle valid_o"}, 128'(valid_o), 128'(0));
      chk({tag, " idle flags"}, 128'({row_end_o, frame_end_o}), 128'(0));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " window_o"}, 128'(window_o), 128'(0));
    chk({tag, " valid_o"}, 128'(valid_o), 128'(0));
    chk({tag, " flags"}, 128'({row_end_o, frame_end_o}), 128'(0));
    chk({tag, " col_o"}, 128'(col_o), 128'(0));
    chk({tag, " row_o"}, 128'(row_o), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      int col;
      int orow;
      col  = i % COLS;
      orow = i / COLS;
      for (int r = 0; r < K; r++) tbl[i].taps[r*DW +: DW] = pix(r, col, orow);
      tbl[i].ev   = (col >= K - 1);
      tbl[i].ere  = (col == COLS - 1);
      tbl[i].efe  = (col == COLS - 1) && (orow == ROWS - K);
      tbl[i].ecol = col;
      tbl[i].erow = orow;
      tbl[i].ewin = '0;
      if (tbl[i].ev) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            tbl[i].ewin[(r*K+c)*DW +: DW] = pix(r, col - (K - 1) + c, orow);
      end
    end

    #2;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: continuous beats.
    pulses = 0;
    for (int i = 0; i < NB; i++) beat(tbl[i], $sformatf("f1[%0d]", i));
    chk("f1 pulse count", 128'(pulses), 128'(12));

    // Frame 2 back-to-back, with idle gaps between beats.
    pulses = 0;
    for (int i = 0; i < NB; i++) begin
      beat(tbl[i], $sformatf("f2[%0d]", i));
      if (i % 3 != 2) idle($urandom_range(0, 2), $sformatf("f2 gap %0d", i));
    end
    chk("f2 pulse count", 128'(pulses), 128'(12));

    // Clear with a concurrent beat at col 4.
    for (int i = 0; i < 4; i++) beat(tbl[i], $sformatf("clr pre[%0d]", i));
    valid_i = 1'b1;
    clear_i = 1'b1;
    taps_i  = tbl[4].taps;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
    chk_zero("clear");
    for (int i = 0; i < 3; i++) beat(tbl[i], $sformatf("clr post[%0d]", i));

    // Asynchronous reset between edges, mid-row.
    beat(tbl[3], "rst pre");
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async rst");
    #1;
    rst = 1'b1;
    for (int i = 0; i < COLS; i++) beat(tbl[i], $sformatf("rst post[%0d]", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
